// File: rtl/kbd_pkg.sv
// Shared constants and types for the PS/2 set-2 key decoder.
//   KB_PFX_EXT : extended-key prefix byte (E0)
//   KB_PFX_BRK : break (key release) prefix byte (F0)
//   kbd_state_e: byte-handling FSM states (idle / pop / process)
package kbd_pkg;

  localparam logic [7:0] KB_PFX_EXT = 8'hE0;
  localparam logic [7:0] KB_PFX_BRK = 8'hF0;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StPop  = 2'd1,
    StProc = 2'd2
  } kbd_state_e;

endpackage

// File: rtl/scancode_ascii.sv
// Combinational ROM: PS/2 set-2 make code -> ASCII.
// Covers uppercase letters, digits 0-9, space and enter; all other codes give 0.
// Ports:
//   i_code  [7:0] : scan code (non-extended)
//   o_ascii [7:0] : ASCII value, or 8'h00 when unmapped
module scancode_ascii (
  input  logic [7:0] i_code,
  output logic [7:0] o_ascii
);

  always_comb begin
    o_ascii = 8'h00;
    case (i_code)
      8'h1C: o_ascii = 8'h41; // A
      8'h32: o_ascii = 8'h42; // B
      8'h21: o_ascii = 8'h43; // C
      8'h23: o_ascii = 8'h44; // D
      8'h24: o_ascii = 8'h45; // E
      8'h2B: o_ascii = 8'h46; // F
      8'h34: o_ascii = 8'h47; // G
      8'h33: o_ascii = 8'h48; // H
      8'h43: o_ascii = 8'h49; // I
      8'h3B: o_ascii = 8'h4A; // J
      8'h42: o_ascii = 8'h4B; // K
      8'h4B: o_ascii = 8'h4C; // L
      8'h3A: o_ascii = 8'h4D; // M
      8'h31: o_ascii = 8'h4E; // N
      8'h44: o_ascii = 8'h4F; // O
      8'h4D: o_ascii = 8'h50; // P
      8'h15: o_ascii = 8'h51; // Q
      8'h2D: o_ascii = 8'h52; // R
      8'h1B: o_ascii = 8'h53; // S
      8'h2C: o_ascii = 8'h54; // T
      8'h3C: o_ascii = 8'h55; // U
      8'h2A: o_ascii = 8'h56; // V
      8'h1D: o_ascii = 8'h57; // W
      8'h22: o_ascii = 8'h58; // X
      8'h35: o_ascii = 8'h59; // Y
      8'h1A: o_ascii = 8'h5A; // Z
      8'h45: o_ascii = 8'h30; // 0
      8'h16: o_ascii = 8'h31; // 1
      8'h1E: o_ascii = 8'h32; // 2
      8'h26: o_ascii = 8'h33; // 3
      8'h25: o_ascii = 8'h34; // 4
      8'h2E: o_ascii = 8'h35; // 5
      8'h36: o_ascii = 8'h36; // 6
      8'h3D: o_ascii = 8'h37; // 7
      8'h3E: o_ascii = 8'h38; // 8
      8'h46: o_ascii = 8'h39; // 9
      8'h29: o_ascii = 8'h20; // space
      8'h5A: o_ascii = 8'h0D; // enter
      default: o_ascii = 8'h00;
    endcase
  end

endmodule

// File: rtl/kbd_decoder.sv
// PS/2 set-2 scan-code decoder sitting behind the ps2_keyboard receive FIFO.
// Pops one byte every three cycles, tracks E0/F0 prefixes and reports key presses.
// Ports:
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_kb_data [7:0]     : FIFO head byte
//   i_kb_ready          : FIFO non-empty
//   i_kb_overflow       : FIFO overflow flag
//   o_kb_nextdata_n     : active-low FIFO pop strobe (one cycle per byte)
//   o_key_pressed       : a key is currently held
//   o_key_code [7:0]    : scan code of the latest make
//   o_key_ext           : latest make carried an E0 prefix
//   o_key_ascii [7:0]   : ASCII of o_key_code, 0 if unmapped or extended
//   o_key_count [CNT_W] : distinct presses, wrapping
//   o_key_event         : one-cycle pulse per new press
//   o_ovf_err           : sticky FIFO overflow indicator
module kbd_decoder
  import kbd_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [7:0]       i_kb_data,
  input  logic             i_kb_ready,
  input  logic             i_kb_overflow,
  output logic             o_kb_nextdata_n,
  output logic             o_key_pressed,
  output logic [7:0]       o_key_code,
  output logic             o_key_ext,
  output logic [7:0]       o_key_ascii,
  output logic [CNT_W-1:0] o_key_count,
  output logic             o_key_event,
  output logic             o_ovf_err
);

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  kbd_state_e       r_state;
  logic [7:0]       r_byte;
  logic             r_ext_pend;
  logic             r_brk_pend;
  logic             r_key_pressed;
  logic [7:0]       r_key_code;
  logic             r_key_ext;
  logic [CNT_W-1:0] r_key_count;
  logic             r_key_event;
  logic             r_ovf_err;

  kbd_state_e       w_state_nxt;
  logic             w_pop_n;
  logic             w_latch;
  logic             w_proc;
  logic             w_ext_pend_nxt;
  logic             w_brk_pend_nxt;
  logic             w_key_pressed_nxt;
  logic [7:0]       w_key_code_nxt;
  logic             w_key_ext_nxt;
  logic [CNT_W-1:0] w_key_count_nxt;
  logic             w_key_event_nxt;
  logic             w_same_key;
  logic [7:0]       w_ascii_raw;

  // FSM: IDLE waits for a byte, POP strobes the FIFO, PROC classifies and
  // leaves the FIFO a cycle to refresh kb_ready before IDLE samples again.
  always_comb begin
    w_state_nxt = r_state;
    w_pop_n     = 1'b1;
    w_latch     = 1'b0;
    w_proc      = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_kb_ready) begin
          w_latch     = 1'b1;
          w_state_nxt = StPop;
        end
      end
      StPop: begin
        w_pop_n     = 1'b0;
        w_state_nxt = StProc;
      end
      StProc: begin
        w_proc      = 1'b1;
        w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // Byte matches the held key including its extended flag.
  assign w_same_key = r_key_pressed && (r_byte == r_key_code) && (r_ext_pend == r_key_ext);

  always_comb begin
    w_ext_pend_nxt    = r_ext_pend;
    w_brk_pend_nxt    = r_brk_pend;
    w_key_pressed_nxt = r_key_pressed;
    w_key_code_nxt    = r_key_code;
    w_key_ext_nxt     = r_key_ext;
    w_key_count_nxt   = r_key_count;
    w_key_event_nxt   = 1'b0;
    if (w_proc) begin
      if (r_byte == KB_PFX_EXT) begin
        w_ext_pend_nxt = 1'b1;
      end else if (r_byte == KB_PFX_BRK) begin
        w_brk_pend_nxt = 1'b1;
      end else begin
        if (r_brk_pend) begin
          // Break of anything but the held key is ignored.
          if (w_same_key) begin
            w_key_pressed_nxt = 1'b0;
          end
        end else if (!w_same_key) begin
          // Typematic repeats of the held key fall through without effect.
          w_key_code_nxt    = r_byte;
          w_key_ext_nxt     = r_ext_pend;
          w_key_pressed_nxt = 1'b1;
          w_key_count_nxt   = r_key_count + CntOne;
          w_key_event_nxt   = 1'b1;
        end
        w_ext_pend_nxt = 1'b0;
        w_brk_pend_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= StIdle;
      r_byte        <= 8'h00;
      r_ext_pend    <= 1'b0;
      r_brk_pend    <= 1'b0;
      r_key_pressed <= 1'b0;
      r_key_code    <= 8'h00;
      r_key_ext     <= 1'b0;
      r_key_count   <= '0;
      r_key_event   <= 1'b0;
      r_ovf_err     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      if (w_latch) begin
        r_byte <= i_kb_data;
      end
      r_ext_pend    <= w_ext_pend_nxt;
      r_brk_pend    <= w_brk_pend_nxt;
      r_key_pressed <= w_key_pressed_nxt;
      r_key_code    <= w_key_code_nxt;
      r_key_ext     <= w_key_ext_nxt;
      r_key_count   <= w_key_count_nxt;
      r_key_event   <= w_key_event_nxt;
      r_ovf_err     <= r_ovf_err | i_kb_overflow;
    end
  end

  scancode_ascii u_scancode_ascii (
    .i_code  (r_key_code),
    .o_ascii (w_ascii_raw)
  );

  assign o_kb_nextdata_n = w_pop_n;
  assign o_key_pressed   = r_key_pressed;
  assign o_key_code      = r_key_code;
  assign o_key_ext       = r_key_ext;
  assign o_key_ascii     = r_key_ext ? 8'h00 : w_ascii_raw;
  assign o_key_count     = r_key_count;
  assign o_key_event     = r_key_event;
  assign o_ovf_err       = r_ovf_err;

endmodule

// File: tb/tb_kbd_decoder.sv
// Self-checking bench for kbd_decoder: FIFO model in front, byte-level reference model,
// table-driven vectors, timing sequences and randomized traffic.
module tb_kbd_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       kb_overflow = 1'b0;
  logic       kb_ready;
  logic [7:0] kb_data;
  logic       kb_nextdata_n;
  logic       key_pressed;
  logic [7:0] key_code;
  logic       key_ext;
  logic [7:0] key_ascii;
  logic [7:0] key_count;
  logic       key_event;
  logic       ovf_err;

  always #5 clk = ~clk;

  kbd_decoder #(.CNT_W(8)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_kb_data       (kb_data),
    .i_kb_ready      (kb_ready),
    .i_kb_overflow   (kb_overflow),
    .o_kb_nextdata_n (kb_nextdata_n),
    .o_key_pressed   (key_pressed),
    .o_key_code      (key_code),
    .o_key_ext       (key_ext),
    .o_key_ascii     (key_ascii),
    .o_key_count     (key_count),
    .o_key_event     (key_event),
    .o_ovf_err       (ovf_err)
  );

  // FIFO model: pushed by the stimulus, popped on the edge that ends the strobe.
  logic [7:0] fifo_mem [4096];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign kb_ready = (rd_ptr != wr_ptr);
  assign kb_data  = fifo_mem[rd_ptr % 4096];

  int cyc = 0;
  int pop_n = 0;
  int ev_cnt = 0;
  int pop_log [64];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!kb_nextdata_n) begin
      if (rd_ptr != wr_ptr) rd_ptr <= rd_ptr + 1;
      if (pop_n < 64) pop_log[pop_n] <= cyc;
      pop_n <= pop_n + 1;
    end
    if (key_event) ev_cnt <= ev_cnt + 1;
  end

  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model at byte level: prefix flags, held key and counters.
  logic       m_ext, m_brk, m_pressed, m_kext;
  logic [7:0] m_code;
  int         m_count, m_events, ev_base;

  function automatic logic [7:0] model_ascii(input logic [7:0] c, input logic e);
    logic [7:0] letters [26];
    logic [7:0] digits [10];
    logic [7:0] r;
    letters = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
                8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
                8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    digits  = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    r = 8'h00;
    for (int i = 0; i < 26; i++) if (letters[i] == c) r = 8'h41 + 8'(i);
    for (int i = 0; i < 10; i++) if (digits[i] == c) r = 8'h30 + 8'(i);
    if (c == 8'h29) r = 8'h20;
    if (c == 8'h5A) r = 8'h0D;
    if (e) r = 8'h00;
    return r;
  endfunction

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_pressed = 0; m_kext = 0; m_code = 8'h00;
    m_count = 0; m_events = 0; ev_base = ev_cnt;
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic same;
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      same = m_pressed && (b == m_code) && (m_ext == m_kext);
      if (m_brk) begin
        if (same) m_pressed = 0;
      end else if (!same) begin
        m_code = b; m_kext = m_ext; m_pressed = 1;
        m_count = (m_count + 1) % 256;
        m_events++;
      end
      m_ext = 0; m_brk = 0;
    end
  endtask

  task automatic push(input logic [7:0] b);
    fifo_mem[wr_ptr % 4096] = b;
    wr_ptr = wr_ptr + 1;
    model_byte(b);
  endtask

  task automatic drain(input int limit);
    int k = 0;
    while (rd_ptr != wr_ptr && k < limit) begin
      @(negedge clk);
      k++;
    end
    chk("drain_timeout", 32'(rd_ptr == wr_ptr), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_pressed"}, 32'(key_pressed), 32'(m_pressed));
    chk({tag, "_code"}, 32'(key_code), 32'(m_code));
    chk({tag, "_ext"}, 32'(key_ext), 32'(m_kext));
    chk({tag, "_ascii"}, 32'(key_ascii), 32'(model_ascii(m_code, m_kext)));
    chk({tag, "_count"}, 32'(key_count), 32'(m_count));
    chk({tag, "_events"}, 32'(ev_cnt - ev_base), 32'(m_events));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    model_reset();
  endtask

  typedef struct {
    logic [39:0] bytes;
    int          n;
    logic        pressed;
    logic [7:0]  code;
    logic        ext;
    logic [7:0]  ascii;
    int          count;
    int          ev;
  } vec_t;

  vec_t tbl [12];

  initial begin
    int ev0, pop0, k, base;
    logic [7:0] pool [10];
    logic [7:0] b;

    // Sequences applied back to back from reset; expectations are cumulative.
    tbl[0]  = '{40'h1C, 1, 1'b1, 8'h1C, 1'b0, 8'h41, 1, 1};
    tbl[1]  = '{40'h1CF0, 2, 1'b0, 8'h1C, 1'b0, 8'h41, 1, 0};
    tbl[2]  = '{40'h1CF01C1C1C, 5, 1'b0, 8'h1C, 1'b0, 8'h41, 2, 1};
    tbl[3]  = '{40'h75E0, 2, 1'b1, 8'h75, 1'b1, 8'h00, 3, 1};
    tbl[4]  = '{40'h75F0, 2, 1'b1, 8'h75, 1'b1, 8'h00, 3, 0};
    tbl[5]  = '{40'h75F0E0, 3, 1'b0, 8'h75, 1'b1, 8'h00, 3, 0};
    tbl[6]  = '{40'h75E0, 2, 1'b1, 8'h75, 1'b1, 8'h00, 4, 1};
    tbl[7]  = '{40'h75E0F0, 3, 1'b0, 8'h75, 1'b1, 8'h00, 4, 0};
    tbl[8]  = '{40'h29E0E0, 3, 1'b1, 8'h29, 1'b1, 8'h00, 5, 1};
    tbl[9]  = '{40'h29, 1, 1'b1, 8'h29, 1'b0, 8'h20, 6, 1};
    tbl[10] = '{40'h5A, 1, 1'b1, 8'h5A, 1'b0, 8'h0D, 7, 1};
    tbl[11] = '{40'h45, 1, 1'b1, 8'h45, 1'b0, 8'h30, 8, 1};

    model_reset();
    do_reset();

    // Reset state
    chk("rst_nextdata_n", 32'(kb_nextdata_n), 32'd1);
    chk("rst_pressed", 32'(key_pressed), 32'd0);
    chk("rst_code", 32'(key_code), 32'd0);
    chk("rst_ext", 32'(key_ext), 32'd0);
    chk("rst_ascii", 32'(key_ascii), 32'd0);
    chk("rst_count", 32'(key_count), 32'd0);
    chk("rst_event", 32'(key_event), 32'd0);
    chk("rst_ovf", 32'(ovf_err), 32'd0);

    // Table-driven vectors
    for (int r = 0; r < 12; r++) begin
      ev0 = ev_cnt;
      pop0 = pop_n;
      @(negedge clk);
      for (int i = 0; i < tbl[r].n; i++) push(tbl[r].bytes[8*i +: 8]);
      drain(100);
      chk($sformatf("v%0d_pressed", r), 32'(key_pressed), 32'(tbl[r].pressed));
      chk($sformatf("v%0d_code", r), 32'(key_code), 32'(tbl[r].code));
      chk($sformatf("v%0d_ext", r), 32'(key_ext), 32'(tbl[r].ext));
      chk($sformatf("v%0d_ascii", r), 32'(key_ascii), 32'(tbl[r].ascii));
      chk($sformatf("v%0d_count", r), 32'(key_count), 32'(tbl[r].count));
      chk($sformatf("v%0d_events", r), 32'(ev_cnt - ev0), 32'(tbl[r].ev));
      chk($sformatf("v%0d_pops", r), 32'(pop_n - pop0), 32'(tbl[r].n));
    end

    // Latency: byte seen in IDLE at cycle N, pop in N+1, outputs and event in N+3.
    @(negedge clk);
    push(8'h16);
    chk("lat_n0_pop", 32'(kb_nextdata_n), 32'd1);
    @(negedge clk);
    chk("lat_n1_pop", 32'(kb_nextdata_n), 32'd0);
    @(negedge clk);
    chk("lat_n2_pop", 32'(kb_nextdata_n), 32'd1);
    chk("lat_n2_code", 32'(key_code), 32'h45);
    chk("lat_n2_event", 32'(key_event), 32'd0);
    @(negedge clk);
    chk("lat_n3_code", 32'(key_code), 32'h16);
    chk("lat_n3_count", 32'(key_count), 32'd9);
    chk("lat_n3_ascii", 32'(key_ascii), 32'h31);
    chk("lat_n3_event", 32'(key_event), 32'd1);
    @(negedge clk);
    chk("lat_n4_event", 32'(key_event), 32'd0);
    check_model("lat");

    // Back-to-back bytes with kb_ready held high
    pop0 = pop_n;
    @(negedge clk);
    push(8'h1E); push(8'hF0); push(8'h1E); push(8'h26); push(8'hF0); push(8'h26);
    drain(100);
    chk("b2b_pops", 32'(pop_n - pop0), 32'd6);
    for (int i = 1; i < 6; i++)
      chk($sformatf("b2b_gap%0d", i), 32'(pop_log[pop0 + i] - pop_log[pop0 + i - 1]), 32'd3);
    check_model("b2b");

    // Overflow is sticky and does not stop decoding
    @(negedge clk);
    kb_overflow = 1;
    @(negedge clk);
    kb_overflow = 0;
    chk("ovf_set", 32'(ovf_err), 32'd1);
    push(8'h1C);
    drain(100);
    chk("ovf_hold", 32'(ovf_err), 32'd1);
    check_model("ovf");

    // Randomized traffic against the reference model
    pool = '{8'hE0, 8'hF0, 8'hF0, 8'h1C, 8'h1C, 8'h75, 8'h29, 8'h5A, 8'h45, 8'h00};
    for (int blk = 0; blk < 30; blk++) begin
      @(negedge clk);
      for (int i = 0; i < 10; i++) begin
        b = pool[$urandom_range(0, 9)];
        if (b == 8'h00) b = 8'($urandom_range(0, 255));
        push(b);
      end
      drain(200);
      check_model($sformatf("rnd%0d", blk));
    end

    // Reset while an F0 sits in PROC: the next 1C must be a fresh make.
    do_reset();
    chk("rst2_ovf", 32'(ovf_err), 32'd0);
    @(negedge clk);
    push(8'h1C);
    drain(100);
    @(negedge clk);
    push(8'hF0);
    k = 0;
    while (kb_nextdata_n && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("mid_pop_seen", 32'(kb_nextdata_n), 32'd0);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    model_reset();
    push(8'h1C);
    drain(100);
    chk("mid_pressed", 32'(key_pressed), 32'd1);
    chk("mid_count", 32'(key_count), 32'd1);
    chk("mid_code", 32'(key_code), 32'h1C);
    check_model("mid");

    // Counter wrap: 255 distinct presses, then one more rolls to zero.
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 255; i++) begin
      b = (i % 2 == 0) ? 8'h16 : 8'h1E;
      push(b); push(8'hF0); push(b);
    end
    drain(5000);
    chk("wrap_255", 32'(key_count), 32'd255);
    check_model("wrap_pre");
    base = ev_cnt;
    @(negedge clk);
    push(8'h26);
    drain(100);
    chk("wrap_0", 32'(key_count), 32'd0);
    chk("wrap_event", 32'(ev_cnt - base), 32'd1);
    check_model("wrap_post");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
